// File: rtl/vis_pkg.sv
package vis_pkg;

  localparam int unsigned COORD_W    = 11;
  localparam int unsigned PIXCNT_W   = 22;
  localparam int unsigned FRAMECNT_W = 16;

  typedef enum logic [1:0] {
    SYNC,
    FRAME,
    WAIT,
    LATCH
  } state_e;

endpackage

// File: rtl/video_timing_cnt.sv
// Video timing tracker: vsync/de edge detection, per-frame column/line/mask
// counters with line geometry error flag, and snapshot registers loaded at
// each frame boundary.
//   run           : counters active (held at 0 when low)
//   vs_rise       : vsync rising edge, combinational from current vsync
//   mask_snap     : mask pixel count of the frame just ended
//   line_snap     : line count of the frame just ended
//   line_err_snap : a line of the frame just ended had a bad width/overflow
module video_timing_cnt
  import vis_pkg::*;
#(
  parameter int unsigned IMG_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                de,
  input  logic                vsync,
  input  logic                mask,
  output logic                vs_rise,
  output logic [PIXCNT_W-1:0] mask_snap,
  output logic [COORD_W-1:0]  line_snap,
  output logic                line_err_snap
);

  logic                vsync_q;
  logic                de_q;
  logic                de_fall;
  logic [COORD_W-1:0]  col_q, col_d;
  logic [COORD_W-1:0]  line_q, line_d;
  logic [COORD_W-1:0]  line_snap_q, line_snap_d;
  logic                line_err_q, line_err_d;
  logic                line_err_snap_q, line_err_snap_d;
  logic [PIXCNT_W-1:0] mask_q, mask_d;
  logic [PIXCNT_W-1:0] mask_snap_q, mask_snap_d;

  assign vs_rise = vsync & ~vsync_q;
  assign de_fall = ~de & de_q;

  always_comb begin
    col_d           = col_q;
    line_d          = line_q;
    line_err_d      = line_err_q;
    mask_d          = mask_q;
    line_snap_d     = line_snap_q;
    line_err_snap_d = line_err_snap_q;
    mask_snap_d     = mask_snap_q;

    // snapshot takes the pre-clear counter values of the ending frame
    if (run && vs_rise) begin
      line_snap_d     = line_q;
      line_err_snap_d = line_err_q;
      mask_snap_d     = mask_q;
    end

    if (!run || vs_rise) begin
      col_d      = '0;
      line_d     = '0;
      line_err_d = 1'b0;
      mask_d     = '0;
    end else begin
      if (de) begin
        col_d = col_q + 1'b1;
        if (col_q == '1) begin
          line_err_d = 1'b1;
        end
      end
      if (de_fall) begin
        if (col_q != COORD_W'(IMG_W)) begin
          line_err_d = 1'b1;
        end
        if (line_q == '1) begin
          line_err_d = 1'b1;
        end
        line_d = line_q + 1'b1;
        col_d  = '0;
      end
      if (de && mask && (mask_q != '1)) begin
        mask_d = mask_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q         <= 1'b0;
      de_q            <= 1'b0;
      col_q           <= '0;
      line_q          <= '0;
      line_err_q      <= 1'b0;
      mask_q          <= '0;
      line_snap_q     <= '0;
      line_err_snap_q <= 1'b0;
      mask_snap_q     <= '0;
    end else begin
      vsync_q         <= vsync;
      de_q            <= de;
      col_q           <= col_d;
      line_q          <= line_d;
      line_err_q      <= line_err_d;
      mask_q          <= mask_d;
      line_snap_q     <= line_snap_d;
      line_err_snap_q <= line_err_snap_d;
      mask_snap_q     <= mask_snap_d;
    end
  end

  assign mask_snap     = mask_snap_q;
  assign line_snap     = line_snap_q;
  assign line_err_snap = line_err_snap_q;

endmodule

// File: rtl/circle_overlay_ctrl.sv
// Frame-level sequencer for the circle overlay: validates the centroid once
// per frame and drives circle centre, overlay enable and status.
//   clk/rst               : pixel clock, synchronous active-high reset
//   de/hsync/vsync/mask   : video timing and object mask
//   x_center/y_center     : centroid from the centroid stage
//   x_out/y_out           : validated circle centre
//   overlay_en/update     : draw enable, 1-cycle reload pulse
//   geom_err/frame_cnt    : last-frame geometry error, completed frames
module circle_overlay_ctrl
  import vis_pkg::*;
#(
  parameter int unsigned IMG_W       = 64,
  parameter int unsigned IMG_H       = 64,
  parameter int unsigned CENT_LAT    = 4,
  parameter int unsigned MIN_PIXELS  = 16,
  parameter int unsigned LOST_FRAMES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  de,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  mask,
  input  logic [COORD_W-1:0]    x_center,
  input  logic [COORD_W-1:0]    y_center,
  output logic [COORD_W-1:0]    x_out,
  output logic [COORD_W-1:0]    y_out,
  output logic                  overlay_en,
  output logic                  update,
  output logic                  geom_err,
  output logic [FRAMECNT_W-1:0] frame_cnt
);

  state_e                state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [3:0]            miss_q, miss_d;
  logic [COORD_W-1:0]    x_q, x_d;
  logic [COORD_W-1:0]    y_q, y_d;
  logic                  en_q, en_d;
  logic                  upd_q, upd_d;
  logic                  geom_q, geom_d;
  logic [FRAMECNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                  geom_new;
  logic                  valid;

  logic                  run;
  logic                  vs_rise;
  logic [PIXCNT_W-1:0]   mask_snap;
  logic [COORD_W-1:0]    line_snap;
  logic                  line_err_snap;
  logic                  unused_hsync;

  assign unused_hsync = hsync;
  assign run          = (state_q != SYNC);

  video_timing_cnt #(
    .IMG_W(IMG_W)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .de           (de),
    .vsync        (vsync),
    .mask         (mask),
    .vs_rise      (vs_rise),
    .mask_snap    (mask_snap),
    .line_snap    (line_snap),
    .line_err_snap(line_err_snap)
  );

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    miss_d      = miss_q;
    x_d         = x_q;
    y_d         = y_q;
    upd_d       = 1'b0;
    geom_d      = geom_q;
    frame_cnt_d = frame_cnt_q;
    geom_new    = 1'b0;
    valid       = 1'b0;

    unique case (state_q)
      SYNC: begin
        if (vs_rise) begin
          state_d = FRAME;
        end
      end
      FRAME: begin
        if (vs_rise) begin
          state_d = WAIT;
          wait_d  = 4'(CENT_LAT - 1);
        end
      end
      WAIT: begin
        if (vs_rise) begin
          geom_d = 1'b1;
          wait_d = 4'(CENT_LAT - 1);
        end else if (wait_q == '0) begin
          state_d = LATCH;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      LATCH: begin
        frame_cnt_d = frame_cnt_q + 1'b1;
        geom_new    = (line_snap != COORD_W'(IMG_H)) | line_err_snap;
        geom_d      = geom_new;
        valid       = !geom_new && (mask_snap >= PIXCNT_W'(MIN_PIXELS));
        if (valid) begin
          x_d    = x_center;
          y_d    = y_center;
          miss_d = '0;
          upd_d  = 1'b1;
        end else if (miss_q < 4'(LOST_FRAMES)) begin
          miss_d = miss_q + 1'b1;
        end
        // a new frame boundary landing on LATCH starts the next wait directly
        if (vs_rise) begin
          state_d = WAIT;
          wait_d  = 4'(CENT_LAT - 1);
        end else begin
          state_d = FRAME;
        end
      end
      default: state_d = SYNC;
    endcase

    en_d = (miss_d < 4'(LOST_FRAMES));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      wait_q      <= '0;
      miss_q      <= 4'(LOST_FRAMES);
      x_q         <= '0;
      y_q         <= '0;
      en_q        <= 1'b0;
      upd_q       <= 1'b0;
      geom_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      miss_q      <= miss_d;
      x_q         <= x_d;
      y_q         <= y_d;
      en_q        <= en_d;
      upd_q       <= upd_d;
      geom_q      <= geom_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign overlay_en = en_q;
  assign update     = upd_q;
  assign geom_err   = geom_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_circle_overlay_ctrl.sv
module tb_circle_overlay_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        mask;
  logic [10:0] x_center;
  logic [10:0] y_center;
  logic [10:0] x_out;
  logic [10:0] y_out;
  logic        overlay_en;
  logic        update;
  logic        geom_err;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  circle_overlay_ctrl #(
    .IMG_W(64),
    .IMG_H(64),
    .CENT_LAT(4),
    .MIN_PIXELS(16),
    .LOST_FRAMES(3)
  ) dut (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync), .mask(mask),
    .x_center(x_center), .y_center(y_center), .x_out(x_out), .y_out(y_out),
    .overlay_en(overlay_en), .update(update), .geom_err(geom_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // h lines; row long_row is 65 pixels wide; mask rectangle rows r0.., cols c0..
  task automatic send_lines(input int h, input int long_row, input int r0, input int rh,
                            input int c0, input int cw);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < ((r == long_row) ? 65 : 64); c++) begin
        de    = 1'b1;
        hsync = 1'b0;
        mask  = (r >= r0) && (r < r0 + rh) && (c >= c0) && (c < c0 + cw);
        tick();
      end
      de    = 1'b0;
      mask  = 1'b0;
      hsync = 1'b1;
      tick();
      tick();
      hsync = 1'b0;
    end
    repeat (3) tick();
  endtask

  // after return, the edge that sampled the vsync rising edge has just passed
  task automatic vs_edge();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0; mask = 1'b0;
    x_center = '0; y_center = '0;
    repeat (3) tick();
    checks++; if (x_out !== 11'd0) begin errors++; $display("FAIL rst_x got %0d exp 0", x_out); end
    checks++; if (y_out !== 11'd0) begin errors++; $display("FAIL rst_y got %0d exp 0", y_out); end
    checks++; if (overlay_en !== 1'b0) begin errors++; $display("FAIL rst_en got %0d exp 0", overlay_en); end
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL rst_upd got %0d exp 0", update); end
    checks++; if (geom_err !== 1'b0) begin errors++; $display("FAIL rst_geom got %0d exp 0", geom_err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_fc got %0d exp 0", frame_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_valid();
    x_center = 11'd30; y_center = 11'd40;
    send_lines(64, -1, 10, 5, 20, 5);
    vs_edge();
    repeat (6) tick();
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL sync_fc got %0d exp 0", frame_cnt); end
    checks++; if (overlay_en !== 1'b0) begin errors++; $display("FAIL sync_en got %0d exp 0", overlay_en); end
    send_lines(64, -1, 10, 5, 20, 5);
    vs_edge();
    for (int i = 0; i < 4; i++) begin
      checks++; if (update !== 1'b0) begin errors++; $display("FAIL lat_upd_e%0d got %0d exp 0", i, update); end
      tick();
    end
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL lat_upd_e4 got %0d exp 0", update); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL lat_fc_e4 got %0d exp 0", frame_cnt); end
    checks++; if (overlay_en !== 1'b0) begin errors++; $display("FAIL lat_en_e4 got %0d exp 0", overlay_en); end
    tick();
    checks++; if (update !== 1'b1) begin errors++; $display("FAIL v1_upd got %0d exp 1", update); end
    checks++; if (x_out !== 11'd30) begin errors++; $display("FAIL v1_x got %0d exp 30", x_out); end
    checks++; if (y_out !== 11'd40) begin errors++; $display("FAIL v1_y got %0d exp 40", y_out); end
    checks++; if (overlay_en !== 1'b1) begin errors++; $display("FAIL v1_en got %0d exp 1", overlay_en); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL v1_fc got %0d exp 1", frame_cnt); end
    checks++; if (geom_err !== 1'b0) begin errors++; $display("FAIL v1_geom got %0d exp 0", geom_err); end
    tick();
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL v1_upd_e6 got %0d exp 0", update); end
  endtask

  task automatic test_loss();
    x_center = 11'd99; y_center = 11'd99;
    for (int k = 1; k <= 3; k++) begin
      send_lines(64, -1, 10, 2, 20, 5);
      vs_edge();
      repeat (5) tick();
      checks++; if (update !== 1'b0) begin errors++; $display("FAIL loss%0d_upd got %0d exp 0", k, update); end
      checks++; if (x_out !== 11'd30) begin errors++; $display("FAIL loss%0d_x got %0d exp 30", k, x_out); end
      checks++; if (y_out !== 11'd40) begin errors++; $display("FAIL loss%0d_y got %0d exp 40", k, y_out); end
      checks++; if (frame_cnt !== 16'(1 + k)) begin errors++; $display("FAIL loss%0d_fc got %0d exp %0d", k, frame_cnt, 1 + k); end
      checks++;
      if (overlay_en !== ((k < 3) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL loss%0d_en got %0d exp %0d", k, overlay_en, (k < 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_recover();
    x_center = 11'd12; y_center = 11'd7;
    send_lines(64, -1, 30, 5, 40, 5);
    vs_edge();
    repeat (4) tick();
    checks++; if (overlay_en !== 1'b0) begin errors++; $display("FAIL rec_en_e4 got %0d exp 0", overlay_en); end
    tick();
    checks++; if (update !== 1'b1) begin errors++; $display("FAIL rec_upd got %0d exp 1", update); end
    checks++; if (x_out !== 11'd12) begin errors++; $display("FAIL rec_x got %0d exp 12", x_out); end
    checks++; if (y_out !== 11'd7) begin errors++; $display("FAIL rec_y got %0d exp 7", y_out); end
    checks++; if (overlay_en !== 1'b1) begin errors++; $display("FAIL rec_en got %0d exp 1", overlay_en); end
    checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL rec_fc got %0d exp 5", frame_cnt); end
  endtask

  task automatic test_geom();
    x_center = 11'd55; y_center = 11'd44;
    send_lines(63, -1, 10, 10, 20, 10);
    vs_edge();
    repeat (5) tick();
    checks++; if (geom_err !== 1'b1) begin errors++; $display("FAIL g63_geom got %0d exp 1", geom_err); end
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL g63_upd got %0d exp 0", update); end
    checks++; if (x_out !== 11'd12) begin errors++; $display("FAIL g63_x got %0d exp 12", x_out); end
    checks++; if (frame_cnt !== 16'd6) begin errors++; $display("FAIL g63_fc got %0d exp 6", frame_cnt); end
    send_lines(64, 30, 10, 10, 20, 10);
    vs_edge();
    repeat (5) tick();
    checks++; if (geom_err !== 1'b1) begin errors++; $display("FAIL g65_geom got %0d exp 1", geom_err); end
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL g65_upd got %0d exp 0", update); end
    checks++; if (overlay_en !== 1'b1) begin errors++; $display("FAIL g65_en got %0d exp 1", overlay_en); end
    checks++; if (frame_cnt !== 16'd7) begin errors++; $display("FAIL g65_fc got %0d exp 7", frame_cnt); end
    send_lines(64, -1, 10, 5, 20, 5);
    vs_edge();
    repeat (5) tick();
    checks++; if (geom_err !== 1'b0) begin errors++; $display("FAIL gok_geom got %0d exp 0", geom_err); end
    checks++; if (update !== 1'b1) begin errors++; $display("FAIL gok_upd got %0d exp 1", update); end
    checks++; if (x_out !== 11'd55) begin errors++; $display("FAIL gok_x got %0d exp 55", x_out); end
    checks++; if (y_out !== 11'd44) begin errors++; $display("FAIL gok_y got %0d exp 44", y_out); end
    checks++; if (frame_cnt !== 16'd8) begin errors++; $display("FAIL gok_fc got %0d exp 8", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    x_center = 11'd3; y_center = 11'd4;
    send_lines(64, -1, 10, 5, 20, 5);
    vs_edge();
    tick();
    vs_edge();
    checks++; if (geom_err !== 1'b1) begin errors++; $display("FAIL b2b_geom_now got %0d exp 1", geom_err); end
    repeat (4) tick();
    checks++; if (frame_cnt !== 16'd8) begin errors++; $display("FAIL b2b_fc_e4 got %0d exp 8", frame_cnt); end
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL b2b_upd_e4 got %0d exp 0", update); end
    tick();
    checks++; if (frame_cnt !== 16'd9) begin errors++; $display("FAIL b2b_fc_e5 got %0d exp 9", frame_cnt); end
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL b2b_upd_e5 got %0d exp 0", update); end
    checks++; if (geom_err !== 1'b1) begin errors++; $display("FAIL b2b_geom got %0d exp 1", geom_err); end
    checks++; if (x_out !== 11'd55) begin errors++; $display("FAIL b2b_x got %0d exp 55", x_out); end
    checks++; if (overlay_en !== 1'b1) begin errors++; $display("FAIL b2b_en got %0d exp 1", overlay_en); end
  endtask

  task automatic test_reset_midframe();
    x_center = 11'd21; y_center = 11'd22;
    send_lines(20, -1, 10, 5, 20, 5);
    rst = 1'b1;
    tick();
    tick();
    checks++; if (x_out !== 11'd0) begin errors++; $display("FAIL mrst_x got %0d exp 0", x_out); end
    checks++; if (overlay_en !== 1'b0) begin errors++; $display("FAIL mrst_en got %0d exp 0", overlay_en); end
    checks++; if (geom_err !== 1'b0) begin errors++; $display("FAIL mrst_geom got %0d exp 0", geom_err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mrst_fc got %0d exp 0", frame_cnt); end
    rst = 1'b0;
    send_lines(44, -1, 0, 5, 20, 5);
    vs_edge();
    repeat (6) tick();
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mrst_sync_fc got %0d exp 0", frame_cnt); end
    checks++; if (update !== 1'b0) begin errors++; $display("FAIL mrst_sync_upd got %0d exp 0", update); end
    send_lines(64, -1, 10, 5, 20, 5);
    vs_edge();
    repeat (5) tick();
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mrst_v_fc got %0d exp 1", frame_cnt); end
    checks++; if (update !== 1'b1) begin errors++; $display("FAIL mrst_v_upd got %0d exp 1", update); end
    checks++; if (x_out !== 11'd21) begin errors++; $display("FAIL mrst_v_x got %0d exp 21", x_out); end
    checks++; if (overlay_en !== 1'b1) begin errors++; $display("FAIL mrst_v_en got %0d exp 1", overlay_en); end
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    tick();
    release dut.frame_cnt_q;
    x_center = 11'd5; y_center = 11'd6;
    send_lines(64, -1, 10, 5, 20, 5);
    vs_edge();
    repeat (5) tick();
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL wrap_fc got %0d exp 0", frame_cnt); end
    checks++; if (update !== 1'b1) begin errors++; $display("FAIL wrap_upd got %0d exp 1", update); end
    checks++; if (y_out !== 11'd6) begin errors++; $display("FAIL wrap_y got %0d exp 6", y_out); end
  endtask

  initial begin
    test_reset();
    test_first_valid();
    test_loss();
    test_recover();
    test_geom();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
